vga_pattern_sequencer: RTL



---
 rtl/vga_pattern_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer
// Generates 640x480@60 Hz VGA timing and drives per-pixel 8-bit R/G/B codes
// for the three R2R DAC channels, plus the digital sync and blank pins.
// Every output is registered and reflects the (h, v) counter state of the
// previous cycle, so sync, blank and colour stay mutually aligned.
//
// Ports:
//   clk         pixel clock (25.175 MHz nominal)
//   rst_n       synchronous active-low reset
//   mode[1:0]   pattern select; takes effect only at a frame boundary
//   pause       1 = hold frame_count (freezes the animated pattern)
//   r/g/b[7:0]  DAC codes, forced to zero while blanked
//   hsync       horizontal sync, active low
//   vsync       vertical sync, active low
//   hblank      1 outside the horizontal active region
//   vblank      1 outside the vertical active region
//   frame_start one-cycle pulse with output pixel (0,0)
//   frame_count frame counter used by the animated pattern
module vga_pattern_sequencer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       pause,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned BAR_W   = H_ACTIVE / 8;
  localparam int unsigned BW      = $clog2(BAR_W);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  typedef enum logic [1:0] {
    PAT_BARS = 2'd0,
    PAT_GREY = 2'd1,
    PAT_XOR  = 2'd2,
    PAT_ANIM = 2'd3
  } pattern_e;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [7:0]    fc_q, fc_d;
  logic [BW-1:0] sub_q, sub_d;
  logic [2:0]    bar_q, bar_d;
  pattern_e      mode_q, mode_d;

  logic          line_end, frame_end, frame_first, active;
  logic [7:0]    x8, y8;
  logic [2:0]    bar_c;
  logic [7:0]    r_d, g_d, b_d;
  logic          hsync_d, vsync_d;

  // Counters, bar tracker and frame counter
  always_comb begin
    line_end    = (h_q == H_LAST);
    frame_end   = line_end && (v_q == V_LAST);
    frame_first = (h_q == '0) && (v_q == '0);

    h_d = line_end ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (line_end) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end

    fc_d = fc_q;
    if (frame_end && !pause) begin
      fc_d = fc_q + 8'd1;
    end

    // Bar index advances every BAR_W pixels and saturates at the last bar;
    // pixels past the active region are blanked so saturation is harmless.
    sub_d = sub_q;
    bar_d = bar_q;
    if (line_end) begin
      sub_d = '0;
      bar_d = '0;
    end else if (sub_q == BAR_LAST) begin
      sub_d = '0;
      if (bar_q != 3'd7) begin
        bar_d = bar_q + 3'd1;
      end
    end else begin
      sub_d = sub_q + 1'b1;
    end

    // Pixel (0,0) uses the freshly sampled mode so the whole frame,
    // including its first pixel, is drawn with one pattern.
    mode_d = frame_first ? pattern_e'(mode) : mode_q;
  end

  // Pixel generation for the current counter state
  always_comb begin
    active  = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    x8      = 8'(h_q);
    y8      = 8'(v_q);
    bar_c   = 3'd7 - bar_q;
    hsync_d = !((h_q >= HS_START) && (h_q < HS_END));
    vsync_d = !((v_q >= VS_START) && (v_q < VS_END));
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    if (active) begin
      unique case (mode_d)
        PAT_BARS: begin
          r_d = {8{bar_c[2]}};
          g_d = {8{bar_c[1]}};
          b_d = {8{bar_c[0]}};
        end
        PAT_GREY: begin
          r_d = x8;
          g_d = x8;
          b_d = x8;
        end
        PAT_XOR: begin
          r_d = x8 ^ y8;
          g_d = x8;
          b_d = y8;
        end
        PAT_ANIM: begin
          r_d = x8 + fc_q;
          g_d = y8 + fc_q;
          b_d = x8 ^ y8;
        end
        default: begin
          r_d = '0;
          g_d = '0;
          b_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q         <= '0;
      v_q         <= '0;
      fc_q        <= '0;
      sub_q       <= '0;
      bar_q       <= '0;
      mode_q      <= PAT_BARS;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      fc_q        <= fc_d;
      sub_q       <= sub_d;
      bar_q       <= bar_d;
      mode_q      <= mode_d;
      r           <= r_d;
      g           <= g_d;
      b           <= b_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      hblank      <= (h_q >= H_ACT_C);
      vblank      <= (v_q >= V_ACT_C);
      frame_start <= frame_first;
      frame_count <= fc_q;
    end
  end

endmodule
